// File: rtl/cla_approx_pkg.sv
// Shared types and configuration checks for the windowed-carry approximate adder.
// Contents:
//   state_e  : pipeline slot state (EMPTY, FULL, CORRECT)
//   cfg_ok() : legal WIDTH/WIN combination check used at elaboration time
package cla_approx_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FULL    = 2'd1,
    CORRECT = 2'd2
  } state_e;

  localparam int MIN_WIDTH = 2;
  localparam int MIN_WIN   = 1;

  function automatic bit cfg_ok(input int width, input int win);
    return (width >= MIN_WIDTH) && (win >= MIN_WIN);
  endfunction

endpackage

// File: rtl/cla_approx_comb.sv
// Combinational windowed-carry adder core.
// Every carry c[i] only looks at the WIN bit positions directly below it;
// carries below WIN still see the whole prefix including cin, so they are exact.
// Ports:
//   a, b, cin          : operands and carry in
//   apx_sum, apx_cout  : approximate (windowed-carry) result
//   ex_sum, ex_cout    : exact a+b+cin
//   err                : approximate {cout,sum} differs from the exact one
module cla_approx_comb
  import cla_approx_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int WIN   = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] apx_sum,
  output logic             apx_cout,
  output logic [WIDTH-1:0] ex_sum,
  output logic             ex_cout,
  output logic             err
);

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH:0]   c;
  logic [WIDTH:0]   ex_full;

  assign p    = a ^ b;
  assign g    = a & b;
  assign c[0] = cin;

  for (genvar i = 1; i <= WIDTH; i++) begin : g_carry
    // Window base; below WIN the window reaches bit 0 and cin takes part.
    localparam int LO      = (i < WIN) ? 0 : i - WIN;
    localparam bit USE_CIN = (i < WIN);
    logic c_win;

    // Ripple through the window starting from a zero carry at its base,
    // equal to OR over j of g[j] & p[j+1..i-1].
    always_comb begin
      c_win = USE_CIN ? cin : 1'b0;
      for (int j = LO; j < i; j++) begin
        c_win = g[j] | (p[j] & c_win);
      end
    end

    assign c[i] = c_win;
  end

  assign apx_sum  = p ^ c[WIDTH-1:0];
  assign apx_cout = c[WIDTH];

  assign ex_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign ex_sum  = ex_full[WIDTH-1:0];
  assign ex_cout = ex_full[WIDTH];

  assign err = ({apx_cout, apx_sum} != ex_full);

endmodule

// File: rtl/cla_approx_pipe.sv
// Registered approximate adder with optional one-cycle exact repair.
// One result slot: EMPTY -> FULL on accept, or EMPTY/FULL -> CORRECT when an
// exact-mode op mispredicts; CORRECT swaps in the exact result and goes FULL.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   in_valid/in_ready           : operand handshake (a, b, cin, mode)
//   out_valid/out_ready         : result handshake (sum, cout, err, exact)
//   cnt_clr, err_cnt            : clear / saturating count of accepted error ops
module cla_approx_pipe
  import cla_approx_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int WIN   = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             err,
  output logic             exact,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] err_cnt
);

  if (!cfg_ok(WIDTH, WIN)) begin : g_bad_cfg
    $error("cla_approx_pipe: illegal WIDTH/WIN");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] apx_sum, ex_sum;
  logic             apx_cout, ex_cout, c_err;

  cla_approx_comb #(
    .WIDTH (WIDTH),
    .WIN   (WIN)
  ) u_comb (
    .a        (a),
    .b        (b),
    .cin      (cin),
    .apx_sum  (apx_sum),
    .apx_cout (apx_cout),
    .ex_sum   (ex_sum),
    .ex_cout  (ex_cout),
    .err      (c_err)
  );

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d, fix_sum_q, fix_sum_d;
  logic             cout_q, cout_d, fix_cout_q, fix_cout_d;
  logic             err_q, err_d, exact_q, exact_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  assign in_ready  = (state_q == EMPTY) || ((state_q == FULL) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == FULL);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign err       = err_q;
  assign exact     = exact_q;
  assign err_cnt   = cnt_q;

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    err_d      = err_q;
    exact_d    = exact_q;
    fix_sum_d  = fix_sum_q;
    fix_cout_d = fix_cout_q;
    cnt_d      = cnt_q;

    case (state_q)
      EMPTY, FULL: begin
        if (accept) begin
          sum_d      = apx_sum;
          cout_d     = apx_cout;
          err_d      = c_err;
          exact_d    = ~c_err;
          // Exact result is kept aside in case this op needs repair.
          fix_sum_d  = ex_sum;
          fix_cout_d = ex_cout;
          state_d    = (mode && c_err) ? CORRECT : FULL;
        end else if ((state_q == FULL) && out_ready) begin
          state_d = EMPTY;
        end
      end
      CORRECT: begin
        // err stays set so the consumer still sees that speculation failed.
        sum_d   = fix_sum_q;
        cout_d  = fix_cout_q;
        exact_d = 1'b1;
        state_d = FULL;
      end
      default: state_d = EMPTY;
    endcase

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (accept && c_err && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      err_q      <= 1'b0;
      exact_q    <= 1'b0;
      fix_sum_q  <= '0;
      fix_cout_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      err_q      <= err_d;
      exact_q    <= exact_d;
      fix_sum_q  <= fix_sum_d;
      fix_cout_q <= fix_cout_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cla_approx_pipe.sv
// Self-checking bench for cla_approx_pipe: directed cases plus random traffic
// compared against an arithmetic reference of the windowed adder and a
// transaction-level model of the result slot.
module tb_cla_approx_pipe;

  localparam int WIDTH = 16;
  localparam int WIN   = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, cin, mode, out_ready, cnt_clr;
  logic [WIDTH-1:0] a, b;

  logic             in_ready, out_valid, cout, err, exact;
  logic [WIDTH-1:0] sum;
  logic [CNT_W-1:0] err_cnt;

  logic             s_in_ready, s_out_valid, s_cout, s_err, s_exact;
  logic [WIDTH-1:0] s_sum;
  logic [1:0]       s_err_cnt;

  always #5 clk = ~clk;

  cla_approx_pipe #(.WIDTH(WIDTH), .WIN(WIN), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .err(err), .exact(exact),
    .cnt_clr(cnt_clr), .err_cnt(err_cnt)
  );

  // Narrow-counter copy driven by the same stimulus, used for saturation.
  cla_approx_pipe #(.WIDTH(WIDTH), .WIN(WIN), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .a(a), .b(b), .cin(cin), .mode(mode), .out_valid(s_out_valid),
    .out_ready(out_ready), .sum(s_sum), .cout(s_cout), .err(s_err), .exact(s_exact),
    .cnt_clr(cnt_clr), .err_cnt(s_err_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Windowed carry into bit i = carry out of the plain sum of the window bits.
  function automatic logic [WIDTH:0] ref_approx(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic ci);
    logic [WIDTH:0] r;
    longint lo, n, s, mask, cbit;
    r = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      if (i == 0) begin
        cbit = longint'(ci);
      end else begin
        lo   = (i < WIN) ? 0 : i - WIN;
        n    = i - lo;
        mask = (longint'(1) << n) - 1;
        s    = ((longint'(x) >> lo) & mask) + ((longint'(y) >> lo) & mask)
             + ((i < WIN) ? longint'(ci) : 0);
        cbit = (s >> n) & 1;
      end
      if (i < WIDTH) r[i] = x[i] ^ y[i] ^ cbit[0];
      else           r[i] = cbit[0];
    end
    return r;
  endfunction

  // Transaction model of the single result slot.
  bit             m_have, m_fixing;
  logic [WIDTH:0] m_res;
  logic           m_err, m_exact;
  int             m_cnt, m_cnt2;

  task automatic model_reset();
    m_have = 0; m_fixing = 0; m_cnt = 0; m_cnt2 = 0;
  endtask

  // One clock: drive at negedge, check outputs, advance model, end at next negedge.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                       input logic ci, input logic md, input logic ordy, input logic clr);
    logic           exp_ov, exp_ir, fire_in;
    logic [WIDTH:0] ex, ap;
    in_valid = v; a = aa; b = bb; cin = ci; mode = md; out_ready = ordy; cnt_clr = clr;
    #1;
    exp_ov = m_have && !m_fixing;
    exp_ir = !m_have || (exp_ov && ordy);
    chk("out_valid", out_valid, exp_ov);
    chk("in_ready", in_ready, exp_ir);
    if (exp_ov) begin
      chk("sum", sum, m_res[WIDTH-1:0]);
      chk("cout", cout, m_res[WIDTH]);
      chk("err", err, m_err);
      chk("exact", exact, m_exact);
    end
    chk("err_cnt", err_cnt, m_cnt);
    chk("err_cnt_sat", s_err_cnt, m_cnt2);

    fire_in = v && exp_ir;
    ex = {1'b0, aa} + {1'b0, bb} + {{WIDTH{1'b0}}, ci};
    ap = ref_approx(aa, bb, ci);
    if (m_fixing) begin
      m_fixing = 0;
    end else begin
      if (exp_ov && ordy) m_have = 0;
      if (fire_in) begin
        m_have   = 1;
        m_err    = (ap != ex);
        m_fixing = md && m_err;
        m_res    = m_fixing ? ex : ap;
        m_exact  = m_fixing ? 1'b1 : !m_err;
      end
    end
    if (clr) begin
      m_cnt = 0; m_cnt2 = 0;
    end else if (fire_in && (ap != ex)) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [WIDTH-1:0] held, ra, rb;
    rst_n = 1'b0; in_valid = 0; a = '0; b = '0; cin = 0; mode = 0;
    out_ready = 0; cnt_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sum", sum, 0);
    chk("rst_err", err, 0);
    chk("rst_exact", exact, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;

    // Approximate mode, chain broken at bit 4.
    cycle(1, 16'h00FF, 16'h0001, 0, 0, 0, 0);
    chk("tp1_sum", sum, 16'h00E0);
    chk("tp1_err", err, 1);
    chk("tp1_exact", exact, 0);
    chk("tp1_cnt", err_cnt, 1);
    cycle(0, 0, 0, 0, 0, 1, 0);

    // Exact mode: one bubble cycle, then the repaired result.
    cycle(1, 16'h00FF, 16'h0001, 0, 1, 1, 0);
    chk("tp2_corr_ov", out_valid, 0);
    chk("tp2_corr_ir", in_ready, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk("tp2_sum", sum, 16'h0100);
    chk("tp2_err", err, 1);
    chk("tp2_exact", exact, 1);
    cycle(0, 0, 0, 0, 0, 1, 0);

    // cin lost at the window boundary, then an error-free op.
    cycle(1, 16'h0008, 16'h0007, 1, 0, 0, 0);
    chk("tp3_sum", sum, 16'h0000);
    chk("tp3_err", err, 1);
    cycle(1, 16'h1234, 16'h0101, 0, 0, 1, 0);
    chk("tp3b_sum", sum, 16'h1335);
    chk("tp3b_err", err, 0);
    chk("tp3b_exact", exact, 1);
    cycle(0, 0, 0, 0, 0, 1, 0);

    // Back-to-back carry-free ops, then back-pressure.
    for (int i = 0; i < 8; i++) begin
      ra = WIDTH'($urandom);
      rb = ~ra & WIDTH'($urandom);
      cycle(1, ra, rb, 0, 0, 1, 0);
    end
    held = sum;
    for (int i = 0; i < 3; i++) cycle(1, WIDTH'($urandom), WIDTH'($urandom), 0, 0, 0, 0);
    chk("bp_hold_sum", sum, held);
    chk("bp_in_ready", in_ready, 0);
    cycle(0, 0, 0, 0, 0, 1, 0);

    // Saturation of the 2-bit counter and clear-over-increment priority.
    cycle(0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) cycle(1, 16'h00FF, 16'h0001, 0, 0, 1, 0);
    chk("sat_cnt", s_err_cnt, 3);
    cycle(1, 16'h00FF, 16'h0001, 0, 0, 1, 1);
    chk("clr_prio_sat", s_err_cnt, 0);
    chk("clr_prio", err_cnt, 0);
    cycle(0, 0, 0, 0, 0, 1, 0);

    // Reset while repairing.
    cycle(1, 16'h00FF, 16'h0001, 0, 1, 1, 0);
    rst_n = 1'b0;
    #1;
    chk("rstc_out_valid", out_valid, 0);
    chk("rstc_err_cnt", err_cnt, 0);
    chk("rstc_sum", sum, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstc_in_ready", in_ready, 1);
    cycle(1, 16'h0F0F, 16'h0101, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 0, 1, 0);

    // Random traffic; operands biased toward long carry chains.
    for (int i = 0; i < 400; i++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ~ra ^ WIDTH'($urandom_range(0, 15));
        1: rb = WIDTH'($urandom_range(0, 31));
        default: rb = WIDTH'($urandom);
      endcase
      cycle(1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
